// File: rtl/rr_mux_n.sv
// N:1 registered multiplexer with per-channel valid/ready, round-robin or fixed-channel grant.
// Optional packet locking (in_last port + lock FSM) is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_n #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     eligible;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             accept;
  logic             locked;
  logic [SEL_W-1:0] lock_chan;

  assign load_en = !out_valid || out_ready;
  assign accept  = grant_vld && load_en && !rst;

`ifdef RR_MUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_chan <= '0;
    end else begin
      state <= state_next;
      if (accept && state == IDLE)
        lock_chan <= grant_idx;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !in_last[grant_idx]) state_next = LOCKED;
      LOCKED:  if (accept &&  in_last[grant_idx]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign locked = (state == LOCKED);
`else
  assign locked    = 1'b0;
  assign lock_chan = '0;
`endif

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < N; k++) begin
      if (locked)
        eligible[k] = in_valid[k] && (lock_chan == SEL_W'(k));
      else
        eligible[k] = in_valid[k] && (!mode || sel == SEL_W'(k));
    end
  end

  // Scan starts at rr_ptr and wraps; in fixed mode at most one channel is eligible anyway.
  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_vld && eligible[SEL_W'(j)]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(j);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++)
      in_ready[k] = accept && (grant_idx == SEL_W'(k));
  end

  // While locked the granted channel is always lock_chan, so rewriting rr_ptr to
  // lock_chan+1 on every beat leaves it frozen at the value it takes on release.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*W +: W];
        out_chan  <= grant_idx;
        rr_ptr    <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Randomised and directed bench for rr_mux_n against a distance-based round-robin reference model.
// Packet-lock checks run only when RR_MUX_PKT_LOCK_EN is defined.
module tb_rr_mux_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [N-1:0]    in_last;
  logic [2:0]      b_last;
`endif

  // Second instance with N=3 so that an out-of-range sel value is expressible.
  logic [3*W-1:0]  b_data;
  logic [2:0]      b_valid;
  logic [2:0]      b_ready;
  logic            b_mode;
  logic [1:0]      b_sel;
  logic [W-1:0]    b_out_data;
  logic [1:0]      b_out_chan;
  logic            b_out_valid;
  logic            b_out_ready;

  always #5 clk = ~clk;

  rr_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(in_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_mux_n #(.N(3), .W(W)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(b_last),
`endif
    .mode(b_mode), .sel(b_sel), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_chan;
  logic [W-1:0] chan_data [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Winner is the eligible channel at the smallest forward distance from the pointer.
  function automatic int model_grant(input logic [N-1:0] v, input logic md, input int s);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int c = 0; c < N; c++) begin
      if (v[c] && (!md || s == c)) begin
        d = (c - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  // Called at a falling edge: drive, check, cross one rising edge, update model, return at next falling edge.
  task automatic step(input logic [N-1:0] v, input logic md, input logic [SW-1:0] s,
                      input logic rdy, output int g);
    bit load;
    logic [N-1:0] exp_ready;
    for (int c = 0; c < N; c++) in_data[c*W +: W] = chan_data[c];
    in_valid  = v;
    mode      = md;
    sel       = s;
    out_ready = rdy;
    #1;
    load      = !m_valid || rdy;
    g         = load ? model_grant(v, md, int'(s)) : -1;
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_chan",  32'(out_chan),  32'(m_chan));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid      = 1'b1;
        m_data       = chan_data[g];
        m_chan       = g;
        m_ptr        = (g + 1) % N;
        chan_data[g] = W'($urandom);
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    in_valid = '1;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_out_chan",  32'(out_chan),  32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(0));
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] pend;
  logic [N-1:0] v;
  logic         md;
  int           g;

  initial begin
    rst         = 1'b1;
    in_valid    = '1;
    in_data     = '0;
    mode        = 1'b0;
    sel         = '0;
    out_ready   = 1'b1;
    b_data      = {8'h33, 8'h22, 8'h11};
    b_valid     = '0;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_out_ready = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
    in_last     = '1;
    b_last      = '1;
`endif
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    for (int c = 0; c < N; c++) chan_data[c] = W'($urandom);
    #1;
    check("init_in_ready",  32'(in_ready),  32'(0));
    check("init_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin fairness with every channel valid
    for (int i = 0; i < 8; i++) begin
      step('1, 1'b0, '0, 1'b1, g);
      check("t2_chan", 32'(out_chan), 32'(i % N));
    end

    // Reset in the middle of a stream
    check("t1_pre_valid", 32'(out_valid), 32'(1));
    do_reset();

    // Out-of-range sel on the N=3 instance: nothing granted, output drains and holds data
    in_valid = '0;
    b_valid  = 3'b111;
    #1 check("t4b_rdy_rr", 32'(b_ready), 32'(3'b001));
    @(negedge clk);
    b_mode = 1'b1;
    b_sel  = 2'd3;
    #1;
    check("t4b_valid1", 32'(b_out_valid), 32'(1));
    check("t4b_data1",  32'(b_out_data),  32'(8'h11));
    check("t4b_rdy_none", 32'(b_ready),   32'(0));
    @(negedge clk);
    #1;
    check("t4b_drained", 32'(b_out_valid), 32'(0));
    check("t4b_hold",    32'(b_out_data),  32'(8'h11));
    check("t4b_chan",    32'(b_out_chan),  32'(0));
    b_valid = '0;
    @(negedge clk);

    // Wrap and skip: channel 1 moves the pointer to 2, then only 1 and 3 compete
    step(4'b0010, 1'b0, '0, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, 1'b0, '0, 1'b1, g);
      check("t3_chan", 32'(out_chan), (i % 2 == 0) ? 32'(3) : 32'(1));
    end

    // Fixed mode on channel 2
    for (int i = 0; i < 4; i++) begin
      step('1, 1'b1, 2'd2, 1'b1, g);
      check("t4_chan", 32'(out_chan), 32'(2));
    end

    // Backpressure holding an A5 beat from channel 0
    chan_data[0] = 8'hA5;
    step('1, 1'b1, 2'd0, 1'b1, g);
    for (int i = 0; i < 3; i++) begin
      step('1, 1'b1, 2'd0, 1'b0, g);
      check("t5_hold", 32'(out_data), 32'(8'hA5));
    end
    step('1, 1'b1, 2'd0, 1'b1, g);

    // Random traffic; a channel that is not accepted keeps its valid and data
    pend = '1 & ~((g >= 0) ? N'(1) << g : '0);
    md   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      v = pend | (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 9) == 0) md = ~md;
      step(v, md, SW'($urandom_range(0, N-1)), ($urandom_range(0, 9) < 7), g);
      pend = v & ~((g >= 0) ? N'(1) << g : '0);
    end

`ifdef RR_MUX_PKT_LOCK_EN
    // Channel 0 sends a 3-beat packet while channel 1 waits
    do_reset();
    in_valid  = 4'b0011;
    mode      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2) ? 4'b1111 : 4'b1110;
      @(posedge clk);
      @(negedge clk);
      #1 check("t6_chan", 32'(out_chan), (i < 3) ? 32'(0) : 32'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
